// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: issues one imem request at a time for the
// current PC, returns the fetched word to the IF/ID register, and holds the
// PC generator until a request is accepted or a redirect arrives.
//
// state | meaning
// ------+--------------------------------------------------------------
// ISSUE | request valid for pc_i, waiting for the memory to accept it
// WAIT  | one request in flight, waiting for its response or a timeout
// HOLD  | response parked in the skid buffer while ID is stalled
module if_fetch_ctrl #(
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013,
    parameter int unsigned RSP_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_i,
    input  logic [31:0] pc_plus_4_i,
    input  logic        flush_i,
    input  logic        stall_id_i,
    output logic        stall_if_o,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    input  logic        imem_rsp_err_i,
    output logic        if_valid_o,
    output logic [31:0] if_instr_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_pc_plus_4_o,
    output logic        if_fault_o
);

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam bit          TMO_EN   = (RSP_TIMEOUT != 0);
    localparam logic [31:0] TMO_LAST = TMO_EN ? 32'(RSP_TIMEOUT - 1) : 32'd0;

    state_t      state_q, state_d;
    logic        drop_q, drop_d;
    logic [31:0] tag_pc_q, tag_pc4_q;
    logic [31:0] tmo_cnt_q;
    logic [31:0] skid_instr_q, skid_pc_q, skid_pc4_q;
    logic        skid_fault_q;

    logic        req_fire, out_free, consumed, tmo_hit, rsp_evt, rsp_fault;
    logic [31:0] rsp_instr;
    logic        tag_load, load_rsp, load_skid, cap_skid;

    assign imem_req_valid_o = (state_q == ST_ISSUE) & rst_n;
    assign imem_req_addr_o  = pc_i;
    assign req_fire         = imem_req_valid_o & imem_req_ready_i;
    // The PC moves once per accepted request, and always takes a redirect.
    assign stall_if_o       = ~(req_fire | flush_i);

    assign out_free  = ~if_valid_o | ~stall_id_i;
    assign consumed  = if_valid_o & ~stall_id_i;
    assign tmo_hit   = TMO_EN && (tmo_cnt_q == TMO_LAST);
    // A timeout is delivered exactly like an error response.
    assign rsp_evt   = (state_q == ST_WAIT) & (imem_rsp_valid_i | tmo_hit);
    assign rsp_fault = imem_rsp_valid_i ? imem_rsp_err_i : 1'b1;
    assign rsp_instr = rsp_fault ? NOP_INSTR : imem_rsp_data_i;

    // State and drop-flag register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_ISSUE;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
        end
    end

    // Next-state and datapath enables; flush wins over any load.
    always_comb begin
        state_d   = state_q;
        drop_d    = drop_q;
        tag_load  = 1'b0;
        load_rsp  = 1'b0;
        load_skid = 1'b0;
        cap_skid  = 1'b0;
        unique case (state_q)
            ST_ISSUE: begin
                if (req_fire) begin
                    tag_load = 1'b1;
                    drop_d   = flush_i;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (rsp_evt) begin
                    // A flush in the response cycle also kills it; nothing more will arrive.
                    drop_d  = 1'b0;
                    state_d = ST_ISSUE;
                    if (!drop_q && !flush_i) begin
                        if (out_free) begin
                            load_rsp = 1'b1;
                        end else begin
                            cap_skid = 1'b1;
                            state_d  = ST_HOLD;
                        end
                    end
                end else if (flush_i) begin
                    drop_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (flush_i) begin
                    state_d = ST_ISSUE;
                end else if (out_free) begin
                    load_skid = 1'b1;
                    state_d   = ST_ISSUE;
                end
            end
            default: state_d = ST_ISSUE;
        endcase
    end

    // Request tags and saturating response timer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_pc_q  <= '0;
            tag_pc4_q <= '0;
            tmo_cnt_q <= '0;
        end else begin
            if (tag_load) begin
                tag_pc_q  <= pc_i;
                tag_pc4_q <= pc_plus_4_i;
                tmo_cnt_q <= '0;
            end else if (state_q == ST_WAIT && tmo_cnt_q != '1) begin
                tmo_cnt_q <= tmo_cnt_q + 32'd1;
            end
        end
    end

    // One-entry skid buffer for a response that arrives while ID is stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= '0;
            skid_pc4_q   <= '0;
            skid_fault_q <= 1'b0;
        end else if (cap_skid) begin
            skid_instr_q <= rsp_instr;
            skid_pc_q    <= tag_pc_q;
            skid_pc4_q   <= tag_pc4_q;
            skid_fault_q <= rsp_fault;
        end
    end

    // IF/ID output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if_valid_o     <= 1'b0;
            if_instr_o     <= NOP_INSTR;
            if_pc_o        <= '0;
            if_pc_plus_4_o <= '0;
            if_fault_o     <= 1'b0;
        end else if (flush_i) begin
            if_valid_o <= 1'b0;
        end else if (load_rsp) begin
            if_valid_o     <= 1'b1;
            if_instr_o     <= rsp_instr;
            if_pc_o        <= tag_pc_q;
            if_pc_plus_4_o <= tag_pc4_q;
            if_fault_o     <= rsp_fault;
        end else if (load_skid) begin
            if_valid_o     <= 1'b1;
            if_instr_o     <= skid_instr_q;
            if_pc_o        <= skid_pc_q;
            if_pc_plus_4_o <= skid_pc4_q;
            if_fault_o     <= skid_fault_q;
        end else if (consumed) begin
            if_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed scenarios followed by random traffic.
// The bench plays PC generator, instruction memory and ID stage; every fetch
// is modelled as a transaction with a 16-cycle deadline, flushes cancel all
// outstanding work, and a scoreboard checks each entry consumed by ID.
module tb_if_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int          TMO = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        fault;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_i, pc_plus_4_i;
    logic        flush_i, stall_id_i, stall_if_o;
    logic        imem_req_valid_o, imem_req_ready_i;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        imem_rsp_err_i;
    logic        if_valid_o;
    logic [31:0] if_instr_o, if_pc_o, if_pc_plus_4_o;
    logic        if_fault_o;

    if_fetch_ctrl #(.NOP_INSTR(NOP), .RSP_TIMEOUT(TMO)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pc_i             (pc_i),
        .pc_plus_4_i      (pc_plus_4_i),
        .flush_i          (flush_i),
        .stall_id_i       (stall_id_i),
        .stall_if_o       (stall_if_o),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .imem_rsp_err_i   (imem_rsp_err_i),
        .if_valid_o       (if_valid_o),
        .if_instr_o       (if_instr_o),
        .if_pc_o          (if_pc_o),
        .if_pc_plus_4_o   (if_pc_plus_4_o),
        .if_fault_o       (if_fault_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        exp_q[$];
    logic [31:0] pc;
    logic        pend, pend_kill;
    logic [31:0] pend_pc;
    int          pend_age, mem_lat;
    logic        last_fire, last_req_valid;
    logic [31:0] last_addr;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive pins, run the transaction model, advance the PC.
    task automatic step(input logic r, input logic f, input logic s, input logic rv,
                        input logic [31:0] rd, input logic re, input logic [31:0] tgt);
        logic fire;
        exp_t e;
        @(negedge clk);
        imem_req_ready_i = r;
        flush_i          = f;
        stall_id_i       = s;
        imem_rsp_valid_i = rv;
        imem_rsp_data_i  = rd;
        imem_rsp_err_i   = re;
        pc_i             = pc;
        pc_plus_4_i      = pc + 32'd4;
        #1;
        fire           = imem_req_valid_o & r;
        last_fire      = fire;
        last_req_valid = imem_req_valid_o;
        last_addr      = imem_req_addr_o;
        check_bit("stall_if", stall_if_o, !(fire | f));
        if (imem_req_valid_o) check_word("req_addr", imem_req_addr_o, pc);
        if (pend) check_bit("one_outstanding", imem_req_valid_o, 1'b0);
        if (pend) begin
            pend_age++;
            if (rv || pend_age == TMO) begin
                if (!pend_kill && !f) begin
                    e.pc    = pend_pc;
                    e.pc4   = pend_pc + 32'd4;
                    e.fault = rv ? re : 1'b1;
                    e.instr = e.fault ? NOP : rd;
                    exp_q.push_back(e);
                end
                pend = 1'b0;
            end
        end
        if (f) begin
            exp_q.delete();
            pend_kill = 1'b1;
        end
        if (fire) begin
            pend      = 1'b1;
            pend_kill = f;
            pend_pc   = pc;
            pend_age  = 0;
            case ($urandom_range(0, 9))
                0:       mem_lat = 0;
                1:       mem_lat = TMO;
                default: mem_lat = int'($urandom_range(1, 4));
            endcase
        end
        @(posedge clk);
        if (f) pc = tgt;
        else if (fire) pc = pc + 32'd4;
    endtask

    // Scoreboard: compare every entry ID consumes; check hold and flush behaviour.
    always @(posedge clk) begin
        exp_t e;
        exp_t cur;
        logic hold, was_flush;
        if (rst_n) begin
            hold      = if_valid_o & stall_id_i & ~flush_i;
            was_flush = flush_i;
            cur.pc    = if_pc_o;
            cur.pc4   = if_pc_plus_4_o;
            cur.instr = if_instr_o;
            cur.fault = if_fault_o;
            if (if_valid_o && !stall_id_i && !flush_i) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got pc %h, expected no entry", if_pc_o);
                end else begin
                    e = exp_q.pop_front();
                    check_word("out_pc", cur.pc, e.pc);
                    check_word("out_pc4", cur.pc4, e.pc4);
                    check_word("out_instr", cur.instr, e.instr);
                    check_bit("out_fault", cur.fault, e.fault);
                end
            end
            #1;
            if (hold) begin
                check_bit("hold_valid", if_valid_o, 1'b1);
                check_word("hold_pc", if_pc_o, cur.pc);
                check_word("hold_instr", if_instr_o, cur.instr);
                check_bit("hold_fault", if_fault_o, cur.fault);
            end
            if (was_flush) check_bit("flush_clears_valid", if_valid_o, 1'b0);
        end
    end

    initial begin
        logic        r, f, s, rv, re;
        logic [31:0] rd, tgt;
        rst_n = 1'b0; pc = '0; pend = 1'b0; pend_kill = 1'b0; pend_pc = '0;
        pend_age = 0; mem_lat = 0;
        pc_i = '0; pc_plus_4_i = 32'd4; flush_i = 1'b0; stall_id_i = 1'b0;
        imem_req_ready_i = 1'b0; imem_rsp_valid_i = 1'b0; imem_rsp_data_i = '0;
        imem_rsp_err_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_bit("rst_valid", if_valid_o, 1'b0);
        check_word("rst_instr", if_instr_o, NOP);
        check_word("rst_pc", if_pc_o, 32'd0);
        check_word("rst_pc4", if_pc_plus_4_o, 32'd0);
        check_bit("rst_fault", if_fault_o, 1'b0);
        check_bit("rst_req_gated", imem_req_valid_o, 1'b0);
        rst_n = 1'b1;
        #1;
        check_bit("req_after_rst", imem_req_valid_o, 1'b1);

        // Zero-wait fetch at PC 0.
        step(1, 0, 0, 0, 0, 0, 0);
        check_bit("t1_fire", last_fire, 1'b1);
        #1 check_bit("t1_not_early", if_valid_o, 1'b0);
        step(0, 0, 0, 1, 32'h0050_0093, 0, 0);
        check_bit("t1_wait_noreq", last_req_valid, 1'b0);
        #1;
        check_bit("t1_valid", if_valid_o, 1'b1);
        check_word("t1_instr", if_instr_o, 32'h0050_0093);
        check_word("t1_pc", if_pc_o, 32'd0);
        check_word("t1_pc4", if_pc_plus_4_o, 32'd4);

        // Memory not ready for three cycles.
        pc = 32'h10;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            check_bit("t2_req_held", last_req_valid, 1'b1);
        end
        step(1, 0, 0, 0, 0, 0, 0);
        check_bit("t2_fire", last_fire, 1'b1);
        check_word("t2_addr", last_addr, 32'h10);
        step(0, 0, 0, 1, 32'h1111_1111, 0, 0);

        // Flush while waiting discards the response.
        pc = 32'h20;
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 32'h80);
        step(0, 0, 0, 1, 32'hDEAD_BEEF, 0, 0);
        #1 check_bit("t3_discard", if_valid_o, 1'b0);
        step(1, 0, 0, 0, 0, 0, 0);
        check_bit("t3_fire", last_fire, 1'b1);
        check_word("t3_addr", last_addr, 32'h80);
        step(0, 0, 0, 1, 32'h2222_2222, 0, 0);

        // ID stall while the next response arrives: skid buffer.
        pc = 32'h40;
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'hAAAA_0040, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0);
        check_word("t4_addr", last_addr, 32'h44);
        step(0, 0, 1, 1, 32'hBBBB_0044, 0, 0);
        #1;
        check_word("t4_hold_pc", if_pc_o, 32'h40);
        check_word("t4_hold_instr", if_instr_o, 32'hAAAA_0040);
        step(1, 0, 1, 0, 0, 0, 0);
        check_bit("t4_noreq_hold", last_req_valid, 1'b0);
        step(1, 0, 0, 0, 0, 0, 0);
        check_bit("t4_noreq_drain", last_req_valid, 1'b0);
        #1;
        check_word("t4_skid_pc", if_pc_o, 32'h44);
        check_word("t4_skid_instr", if_instr_o, 32'hBBBB_0044);

        // Access error.
        pc = 32'h100;
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h1234_5678, 1, 0);
        #1;
        check_bit("t5_fault", if_fault_o, 1'b1);
        check_word("t5_instr", if_instr_o, NOP);
        check_word("t5_pc", if_pc_o, 32'h100);

        // Timeout, then a late response that must be ignored.
        pc = 32'h200;
        step(1, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            step(0, 0, 0, k == 20, 32'hCAFE_F00D, 0, 0);
            #1;
            if (k == 15) check_bit("t6_not_early", if_valid_o, 1'b0);
            if (k == 16) begin
                check_bit("t6_valid", if_valid_o, 1'b1);
                check_bit("t6_fault", if_fault_o, 1'b1);
                check_word("t6_instr", if_instr_o, NOP);
                check_word("t6_pc", if_pc_o, 32'h200);
            end
            if (k == 20) check_bit("t6_late_ignored", if_valid_o, 1'b0);
        end
        step(1, 0, 0, 0, 0, 0, 0);
        check_bit("t6_refire", last_fire, 1'b1);
        check_word("t6_addr", last_addr, 32'h204);
        step(0, 0, 0, 1, 32'h3333_3333, 0, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 3) != 0);
            f   = ($urandom_range(0, 14) == 0);
            s   = ($urandom_range(0, 2) == 0);
            rv  = pend ? ((mem_lat != 0) && (pend_age + 1 == mem_lat))
                       : ($urandom_range(0, 7) == 0);
            rd  = $urandom;
            re  = ($urandom_range(0, 7) == 0);
            tgt = {18'd0, 12'($urandom_range(0, 4095)), 2'b00};
            step(r, f, s, rv, rd, re, tgt);
        end

        // Drain: no new requests, ID always ready.
        for (int i = 0; i < 40; i++) begin
            rv = pend && (mem_lat != 0) && (pend_age + 1 == mem_lat);
            step(0, 0, 0, rv, $urandom, 0, pc);
        end
        #1;
        check_word("drain_empty", 32'(exp_q.size()), 32'd0);
        check_bit("drain_valid", if_valid_o, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
